io_output_reg: RTL

Memory-mapped output port block, the write-side counterpart of the CPU's I/O input registers. The MEM stage issues stores to I/O addresses. The block holds three 32-bit output ports that drive board outputs (LEDs, 7-segment). Each port supports byte-masked write, set, clear and toggle operations, plus read-back. A stretched per-port update strobe lets slow external logic detect changes.

---
 rtl/io_pkg.sv | 24 ++
 rtl/io_output_port.sv | 59 +++++
 rtl/io_output_reg.sv | 74 +++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O output register block:
// op encodings, port count and address field positions.
package io_pkg;

  localparam logic [1:0] IO_OP_WRITE  = 2'b00;
  localparam logic [1:0] IO_OP_SET    = 2'b01;
  localparam logic [1:0] IO_OP_CLEAR  = 2'b10;
  localparam logic [1:0] IO_OP_TOGGLE = 2'b11;

  localparam int IO_NPORTS       = 3;
  localparam int IO_PORT_IDX_LSB = 2;
  localparam int IO_PORT_IDX_MSB = 5;
  localparam int IO_OP_LSB       = 6;
  localparam int IO_IDX_W =
    IO_PORT_IDX_MSB - IO_PORT_IDX_LSB + 1;

  function automatic logic [31:0] io_be_mask(
    input logic [3:0] be
  );
    return {{8{be[3]}}, {8{be[2]}},
            {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/io_output_port.sv
// One output port: value register, masked write/set/clear/toggle
// ALU, and a retriggerable stretched change strobe.
module io_output_port
  import io_pkg::*;
#(
  parameter logic [31:0] RESET_VAL  = 32'h0000_0000,
  parameter int unsigned UPD_CYCLES = 4
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic        i_sel,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_mask,
  input  logic [31:0] i_data,
  output logic [31:0] o_value,
  output logic        o_upd
);

  localparam logic [7:0] LP_UPD = 8'(UPD_CYCLES);

  logic [31:0] r_value;
  logic [7:0]  r_cnt;
  logic [31:0] w_dm;
  logic [31:0] w_next;
  logic        w_chg;

  assign w_dm = i_data & i_mask;

  always_comb begin
    w_next = r_value;
    unique case (i_op)
      IO_OP_WRITE:  w_next = (r_value & ~i_mask) | w_dm;
      IO_OP_SET:    w_next = r_value | w_dm;
      IO_OP_CLEAR:  w_next = r_value & ~w_dm;
      IO_OP_TOGGLE: w_next = r_value ^ w_dm;
      default:      w_next = r_value;
    endcase
  end

  // Only value-changing writes (re)arm the strobe.
  assign w_chg = i_sel && (w_next != r_value);

  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      r_value <= RESET_VAL;
      r_cnt   <= 8'd0;
    end else begin
      if (i_sel) r_value <= w_next;
      if (w_chg)
        r_cnt <= LP_UPD;
      else if (r_cnt != 8'd0)
        r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_value = r_value;
  assign o_upd   = (r_cnt != 8'd0);

endmodule

// File: rtl/io_output_reg.sv
// Memory-mapped output register block: address decode, three
// output ports and the combinational read-back mux.
module io_output_reg
  import io_pkg::*;
#(
  parameter logic [31:0] RESET_VAL  = 32'h0000_0000,
  parameter int unsigned UPD_CYCLES = 4
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wm_en,
  input  logic [3:0]  byte_en,
  input  logic [31:0] io_write_data,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic [2:0]  port_upd,
  output logic [31:0] io_read_data
);

  if (UPD_CYCLES < 1 || UPD_CYCLES > 255) begin : g_bad_upd
    $error("io_output_reg: UPD_CYCLES must be 1..255");
  end

  logic [1:0]           w_op;
  logic [IO_IDX_W-1:0]  w_idx;
  logic [31:0]          w_mask;
  logic [IO_NPORTS-1:0] w_sel;
  logic [IO_NPORTS-1:0] w_upd;
  logic [31:0]          w_val [IO_NPORTS];
  logic                 w_unused;

  assign w_op   = addr[IO_OP_LSB+1:IO_OP_LSB];
  assign w_idx  = addr[IO_PORT_IDX_MSB:IO_PORT_IDX_LSB];
  assign w_mask = io_be_mask(byte_en);

  assign w_unused = ^{addr[31:8], addr[1:0]};

  for (genvar i = 0; i < IO_NPORTS; i++) begin : g_port
    assign w_sel[i] = wm_en && (w_idx == IO_IDX_W'(i));

    io_output_port #(
      .RESET_VAL  (RESET_VAL),
      .UPD_CYCLES (UPD_CYCLES)
    ) u_port (
      .io_clk  (io_clk),
      .reset   (reset),
      .i_sel   (w_sel[i]),
      .i_op    (w_op),
      .i_mask  (w_mask),
      .i_data  (io_write_data),
      .o_value (w_val[i]),
      .o_upd   (w_upd[i])
    );
  end

  assign out_port0 = w_val[0];
  assign out_port1 = w_val[1];
  assign out_port2 = w_val[2];
  assign port_upd  = w_upd;

  // Read-back ignores op and wm_en; unmapped indices read 0.
  always_comb begin
    io_read_data = 32'h0;
    unique case (1'b1)
      (w_idx == IO_IDX_W'(0)): io_read_data = w_val[0];
      (w_idx == IO_IDX_W'(1)): io_read_data = w_val[1];
      (w_idx == IO_IDX_W'(2)): io_read_data = w_val[2];
      default:                 io_read_data = 32'h0;
    endcase
  end

endmodule
